// File: rtl/multi_door_visitor_counter_pkg.sv
// Shared types and defaults for the multi-door visitor counter: door FSM state
// encoding, default occupancy ceiling / timeout, and a small popcount helper.
package multi_door_visitor_counter_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_IN1  = 3'd1,
      ST_IN2  = 3'd2,
      ST_OUT1 = 3'd3,
      ST_OUT2 = 3'd4
   } door_state_t;

   localparam int DEF_MAX_OCC     = 200;
   localparam int DEF_TIMEOUT_CYC = 64;

   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] c;
      c = 4'd0;
      for (int i = 0; i < 8; i++) begin
         c = c + {3'd0, v[i]};
      end
      return c;
   endfunction

endpackage

// File: rtl/multi_door_visitor_counter_door_direction_fsm.sv
// One doorway: 2-flop sensor synchronisers, IDLE/IN1/IN2/OUT1/OUT2 direction FSM
// with a no-progress timeout, and registered one-cycle entry/exit pulses.
module door_direction_fsm
   import multi_door_visitor_counter_pkg::*;
#(
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input  logic clk,
   input  logic reset,
   input  logic ir1,
   input  logic ir2,
   output logic entry_pulse,
   output logic exit_pulse
);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   logic [1:0]    sync1_r, sync2_r;
   logic          s1_s, s2_s, clear_s, timeout_s;
   door_state_t   state_r, nat_next_s, next_state_s;
   logic [TW-1:0] tmo_cnt_r;
   logic          lock_r, entry_s, exit_s, entry_r, exit_r;

   // two-flop synchronisers for the asynchronous sensor inputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_r <= 2'b00;
         sync2_r <= 2'b00;
      end else begin
         sync1_r <= {sync1_r[0], ir1};
         sync2_r <= {sync2_r[0], ir2};
      end
   end

   assign s1_s      = sync1_r[1];
   assign s2_s      = sync2_r[1];
   assign clear_s   = !s1_s && !s2_s;
   assign timeout_s = (state_r != ST_IDLE) && (tmo_cnt_r == TW'(TIMEOUT_CYC - 1));

   // state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // no-progress counter; after an abort the door stays locked in IDLE until both beams clear,
   // so a still-blocked sensor cannot re-arm a half crossing
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tmo_cnt_r <= {TW{1'b0}};
         lock_r    <= 1'b0;
      end else begin
         if (state_r != next_state_s || state_r == ST_IDLE) begin
            tmo_cnt_r <= {TW{1'b0}};
         end else begin
            tmo_cnt_r <= tmo_cnt_r + TW'(1);
         end
         if (timeout_s) begin
            lock_r <= 1'b1;
         end else if (clear_s) begin
            lock_r <= 1'b0;
         end else begin
            lock_r <= lock_r;
         end
      end
   end

   // next-state logic
   always_comb begin
      nat_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (lock_r)               nat_next_s = ST_IDLE;
            else if (s1_s && !s2_s)   nat_next_s = ST_IN1;
            else if (!s1_s && s2_s)   nat_next_s = ST_OUT1;
            else                      nat_next_s = ST_IDLE;
         end
         ST_IN1: begin
            if (s2_s)                 nat_next_s = ST_IN2;
            else if (!s1_s)           nat_next_s = ST_IDLE;
            else                      nat_next_s = ST_IN1;
         end
         ST_IN2: begin
            if (clear_s)              nat_next_s = ST_IDLE;
            else if (s1_s && !s2_s)   nat_next_s = ST_IN1;
            else                      nat_next_s = ST_IN2;
         end
         ST_OUT1: begin
            if (s1_s)                 nat_next_s = ST_OUT2;
            else if (!s2_s)           nat_next_s = ST_IDLE;
            else                      nat_next_s = ST_OUT1;
         end
         ST_OUT2: begin
            if (clear_s)              nat_next_s = ST_IDLE;
            else if (!s1_s && s2_s)   nat_next_s = ST_OUT1;
            else                      nat_next_s = ST_OUT2;
         end
         default:                     nat_next_s = ST_IDLE;
      endcase
      next_state_s = timeout_s ? ST_IDLE : nat_next_s;
   end

   // event decode: a crossing completes when both beams clear from the far-side state
   always_comb begin
      entry_s = 1'b0;
      exit_s  = 1'b0;
      entry_s = !timeout_s && (state_r == ST_IN2)  && clear_s;
      exit_s  = !timeout_s && (state_r == ST_OUT2) && clear_s;
   end

   // registered event pulses
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         entry_r <= 1'b0;
         exit_r  <= 1'b0;
      end else begin
         entry_r <= entry_s;
         exit_r  <= exit_s;
      end
   end

   assign entry_pulse = entry_r;
   assign exit_pulse  = exit_r;

endmodule

// File: rtl/multi_door_visitor_counter.sv
// Multi-door occupancy counter: one direction FSM per door, per-cycle combining of all
// door events into a clamped occupancy count, lifetime entry total and sticky flags.
module multi_door_visitor_counter
   import multi_door_visitor_counter_pkg::*;
#(
   parameter int NUM_DOORS   = 2,
   parameter int COUNT_W     = 8,
   parameter int TOTAL_W     = 16,
   parameter int MAX_OCC     = DEF_MAX_OCC,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_DOORS-1:0] ir_sensor1,
   input  logic [NUM_DOORS-1:0] ir_sensor2,
   input  logic                 clear_flags,
   output logic [COUNT_W-1:0]   curr_visitor,
   output logic [TOTAL_W-1:0]   total_entries,
   output logic                 full,
   output logic                 empty,
   output logic                 overflow,
   output logic                 underflow,
   output logic [NUM_DOORS-1:0] entry_pulse,
   output logic [NUM_DOORS-1:0] exit_pulse
);
   localparam int SW = COUNT_W + 2;

   logic [3:0]           n_in_s, n_out_s;
   logic signed [SW-1:0] sum_s;
   logic [COUNT_W-1:0]   curr_r, next_curr_s;
   logic [TOTAL_W-1:0]   total_r;
   logic                 ovf_r, unf_r, ovf_set_s, unf_set_s, ovf_next_s, unf_next_s;

   for (genvar g = 0; g < NUM_DOORS; g++) begin : g_door
      door_direction_fsm #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_door (
         .clk         (clk),
         .reset       (reset),
         .ir1         (ir_sensor1[g]),
         .ir2         (ir_sensor2[g]),
         .entry_pulse (entry_pulse[g]),
         .exit_pulse  (exit_pulse[g])
      );
   end

   // combine all doors, then clamp; simultaneous entry+exit nets out before clamping
   always_comb begin
      n_in_s      = popcount8(8'(entry_pulse));
      n_out_s     = popcount8(8'(exit_pulse));
      sum_s       = $signed({2'b00, curr_r}) + $signed(SW'(n_in_s)) - $signed(SW'(n_out_s));
      ovf_set_s   = 1'b0;
      unf_set_s   = 1'b0;
      next_curr_s = curr_r;
      if (sum_s > $signed(SW'(MAX_OCC))) begin
         next_curr_s = COUNT_W'(MAX_OCC);
         ovf_set_s   = 1'b1;
      end else if (sum_s[SW-1]) begin
         next_curr_s = {COUNT_W{1'b0}};
         unf_set_s   = 1'b1;
      end else begin
         next_curr_s = sum_s[COUNT_W-1:0];
      end
      ovf_next_s = ovf_set_s | (ovf_r & ~clear_flags);
      unf_next_s = unf_set_s | (unf_r & ~clear_flags);
   end

   // occupancy, lifetime total and sticky flags
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         curr_r  <= {COUNT_W{1'b0}};
         total_r <= {TOTAL_W{1'b0}};
         ovf_r   <= 1'b0;
         unf_r   <= 1'b0;
      end else begin
         curr_r  <= next_curr_s;
         total_r <= total_r + TOTAL_W'(n_in_s);
         ovf_r   <= ovf_next_s;
         unf_r   <= unf_next_s;
      end
   end

   assign curr_visitor  = curr_r;
   assign total_entries = total_r;
   assign overflow      = ovf_r;
   assign underflow     = unf_r;
   assign full          = (curr_r == COUNT_W'(MAX_OCC));
   assign empty         = (curr_r == {COUNT_W{1'b0}});

endmodule
